uart_tx_arbiter: RTL and testbench

- Shares one byte-level UART transmitter core between NUM_REQ independent requesters (e.g. a button-triggered banner sender, an RX echo path, a status reporter).
- Each requester offers a packet of bytes on a valid/ready stream with a last flag.
- The arbiter grants one requester per packet in round-robin order, feeds its bytes to the TX core via a start/busy handshake, and releases the grant at packet end or after MAX_PKT bytes.
- Sits between the requester logic and the UART TX serializer, in the clk domain.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM states, timing constants and sizing helper for the UART transmit path.
package uart_pkg;

  localparam int MAX_REQ         = 8;
  localparam int DELAY_FRAMES    = 234;
  localparam int HALF_DELAY_WAIT = DELAY_FRAMES / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } arbState_t;

  // Index width for n requesters, never below one bit.
  function automatic int clog2_req(input int n);
    int w;
    w = 1;
    for (int i = 1; i < MAX_REQ; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2_req(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  logic [NUM_REQ-1:0] rotReq;

  // Bit i of rotReq is requester (ptr + i) mod NUM_REQ.
  assign rotReq = NUM_REQ'({req, req} >> ptr);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rotReq[i]) begin
        found = 1'b1;
        idx   = IDW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX core; request to first tx_start is 3 cycles, 2-cycle inter-byte gap.
// A grant is held through req_valid gaps and tx_busy stalls until the last byte or MAX_PKT bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_PKT      = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int IDW = clog2_req(NUM_REQ);
  localparam int TW  = $clog2(BUSY_TIMEOUT + 1);

  arbState_t          state, nextState;
  logic [IDW-1:0]     rrPtr, grantIdx, pickIdx;
  logic               pickFound;
  logic [7:0]         byteCnt;
  logic [TW-1:0]      busyCnt;
  logic               lastFlag;
  logic               acceptByte, fireStart, timeoutHit, byteDone, releaseNow;
  logic [NUM_REQ-1:0] readyNext;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) picker (
    .req   (req_valid),
    .ptr   (rrPtr),
    .found (pickFound),
    .idx   (pickIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (pickFound) nextState = LOAD;
      LOAD:      if (acceptByte) nextState = START;
      START:     if (fireStart) nextState = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)         nextState = WAIT_DONE;
        else if (timeoutHit) nextState = releaseNow ? IDLE : LOAD;
      end
      WAIT_DONE: if (byteDone) nextState = releaseNow ? IDLE : LOAD;
      default:   nextState = IDLE;
    endcase
  end

  // A timed-out byte counts as sent and exits exactly like a tx_busy fall.
  always_comb begin
    acceptByte = (state == LOAD) && req_valid[grantIdx];
    fireStart  = (state == START) && !tx_busy;
    timeoutHit = (state == WAIT_BUSY) && !tx_busy && (busyCnt == TW'(BUSY_TIMEOUT - 1));
    byteDone   = timeoutHit || ((state == WAIT_DONE) && !tx_busy);
    releaseNow = byteDone && (lastFlag || (byteCnt == 8'(MAX_PKT)));
    readyNext  = '0;
    if (acceptByte) readyNext[grantIdx] = 1'b1;
  end

  assign grant_id = 3'(grantIdx);

  // req_ready reports the byte captured on the previous edge; the requester pops on seeing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grantIdx    <= '0;
      timeout_err <= 1'b0;
      rrPtr       <= '0;
      byteCnt     <= '0;
      busyCnt     <= '0;
      lastFlag    <= 1'b0;
    end else begin
      req_ready <= readyNext;
      tx_start  <= fireStart;
      busyCnt   <= (state == WAIT_BUSY) ? busyCnt + 1'b1 : '0;
      if (state == IDLE && pickFound) begin
        grantIdx    <= pickIdx;
        grant_valid <= 1'b1;
        byteCnt     <= '0;
      end
      if (acceptByte) begin
        tx_data  <= req_data[8*grantIdx +: 8];
        lastFlag <= req_last[grantIdx];
        byteCnt  <= byteCnt + 8'd1;
      end
      if (timeoutHit) timeout_err <= 1'b1;
      if (releaseNow) begin
        grant_valid <= 1'b0;
        rrPtr       <= (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: requester queues and a TX core model around uart_tx_arbiter.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, grant_valid, timeout_err;
  logic [7:0]  tx_data;
  logic [2:0]  grant_id;

  int total = 0;
  int bad = 0;

  logic [8:0] qMem [4][32];
  int qHead [4];
  int qTail [4];

  int   busyLen = 4;
  int   busyLeft = 0;
  logic neverBusy = 1'b0;
  logic forceBusy = 1'b0;

  logic [7:0] startData [64];
  int   startGid [64];
  int   startCnt = 0;
  int   grantLog [16];
  int   grantCnt = 0;
  int   readyCnt [4];
  int   violations = 0;
  logic prevStart = 1'b0;
  logic prevGv = 1'b0;
  logic [3:0] prevRdy = 4'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .MAX_PKT(16), .BUSY_TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic drive();
    for (int r = 0; r < 4; r++) begin
      req_valid[r]       = (qHead[r] != qTail[r]);
      req_data[8*r +: 8] = qMem[r][qHead[r] % 32][7:0];
      req_last[r]        = qMem[r][qHead[r] % 32][8];
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qMem[r][qTail[r] % 32] = {l, d};
    qTail[r]++;
  endtask

  task automatic clearLogs();
    startCnt = 0;
    grantCnt = 0;
    violations = 0;
    for (int r = 0; r < 4; r++) readyCnt[r] = 0;
  endtask

  // TX core model, requester pop logic and protocol monitor, all at the falling edge.
  initial begin
    for (int r = 0; r < 4; r++) begin qHead[r] = 0; qTail[r] = 0; readyCnt[r] = 0; end
    tx_busy = 1'b0;
    drive();
    forever begin
      @(negedge clk);
      if (busyLeft > 0) busyLeft--;
      if (tx_start && !neverBusy) busyLeft = busyLen;
      tx_busy = forceBusy || (busyLeft > 0);
      if (tx_start) begin
        if (prevStart) violations++;
        if (startCnt < 64) begin
          startData[startCnt] = tx_data;
          startGid[startCnt]  = int'(grant_id);
        end
        startCnt++;
      end
      if (grant_valid && !prevGv) begin
        if (grantCnt < 16) grantLog[grantCnt] = int'(grant_id);
        grantCnt++;
      end
      if ((req_ready & prevRdy) != 4'b0) violations++;
      if (req_ready != 4'b0 && (!grant_valid || req_ready != (4'b0001 << grant_id))) violations++;
      for (int r = 0; r < 4; r++) begin
        if (req_ready[r]) begin
          readyCnt[r]++;
          if (qHead[r] != qTail[r]) qHead[r]++;
        end
      end
      prevStart = tx_start;
      prevGv    = grant_valid;
      prevRdy   = req_ready;
      #2 drive();
    end
  end

  task automatic doReset();
    reset = 1'b1;
    neverBusy = 1'b0;
    forceBusy = 1'b0;
    busyLen = 4;
    for (int r = 0; r < 4; r++) begin qHead[r] = 0; qTail[r] = 0; end
    for (int k = 0; k < 3000 && tx_busy; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clearLogs();
  endtask

  task automatic test_reset();
    doReset();
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_single();
    doReset();
    busyLen = 2340;
    push(0, 8'h4C, 1'b0);
    push(0, 8'h75, 1'b0);
    push(0, 8'h73, 1'b1);
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_first_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_latency: tx_start got %b want 1", tx_start); end
    total++; if (tx_data !== 8'h4C) begin bad++; $display("FAIL single_first_data: got %h want 4c", tx_data); end
    for (int k = 0; k < 10000 && grant_valid; k++) @(negedge clk);
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL single_release: grant_valid got %b want 0", grant_valid); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_release_after_busy: tx_busy got %b want 0", tx_busy); end
    total++; if (startCnt != 3) begin bad++; $display("FAIL single_start_count: got %0d want 3", startCnt); end
    total++; if (startData[0] !== 8'h4C || startData[1] !== 8'h75 || startData[2] !== 8'h73) begin
      bad++; $display("FAIL single_data_seq: got %h %h %h want 4c 75 73", startData[0], startData[1], startData[2]);
    end
    total++; if (readyCnt[0] != 3) begin bad++; $display("FAIL single_ready_count: got %0d want 3", readyCnt[0]); end
    total++; if (grantCnt != 1) begin bad++; $display("FAIL single_grant_count: got %0d want 1", grantCnt); end
    total++; if (violations != 0) begin bad++; $display("FAIL single_protocol: got %0d violations want 0", violations); end
    // Pointer now at 1: with 0 and 1 both requesting, 1 must win.
    busyLen = 4;
    clearLogs();
    push(0, 8'h01, 1'b1);
    push(1, 8'h02, 1'b1);
    for (int k = 0; k < 200 && (startCnt < 2 || grant_valid); k++) @(negedge clk);
    total++; if (grantCnt != 2 || grantLog[0] != 1 || grantLog[1] != 0) begin
      bad++; $display("FAIL single_rr_pointer: got cnt=%0d order %0d,%0d want 2 grants 1,0", grantCnt, grantLog[0], grantLog[1]);
    end
    total++; if (startData[0] !== 8'h02) begin bad++; $display("FAIL single_rr_data: got %h want 02", startData[0]); end
  endtask

  task automatic test_alternate();
    doReset();
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b1);
    push(2, 8'hC1, 1'b1);
    for (int k = 0; k < 500 && (startCnt < 4 || grant_valid); k++) @(negedge clk);
    total++; if (grantCnt != 4) begin bad++; $display("FAIL alt_grant_count: got %0d want 4", grantCnt); end
    total++; if (grantLog[0] != 0 || grantLog[1] != 2 || grantLog[2] != 0 || grantLog[3] != 2) begin
      bad++; $display("FAIL alt_order: got %0d,%0d,%0d,%0d want 0,2,0,2", grantLog[0], grantLog[1], grantLog[2], grantLog[3]);
    end
    total++; if (startData[0] !== 8'hA0 || startData[1] !== 8'hC0 || startData[2] !== 8'hA1 || startData[3] !== 8'hC1) begin
      bad++; $display("FAIL alt_data: got %h %h %h %h want a0 c0 a1 c1", startData[0], startData[1], startData[2], startData[3]);
    end
    total++; if (violations != 0) begin bad++; $display("FAIL alt_protocol: got %0d violations want 0", violations); end
  endtask

  task automatic test_maxpkt();
    doReset();
    for (int i = 0; i < 20; i++) push(1, 8'(i), 1'b0);
    push(3, 8'hEE, 1'b1);
    for (int k = 0; k < 3000 && startCnt < 21; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    total++; if (startCnt != 21) begin bad++; $display("FAIL maxpkt_start_count: got %0d want 21", startCnt); end
    total++; if (startData[15] !== 8'h0F || startGid[15] != 1) begin
      bad++; $display("FAIL maxpkt_byte16: got %h id %0d want 0f id 1", startData[15], startGid[15]);
    end
    total++; if (startData[16] !== 8'hEE || startGid[16] != 3) begin
      bad++; $display("FAIL maxpkt_other_req: got %h id %0d want ee id 3", startData[16], startGid[16]);
    end
    total++; if (startData[17] !== 8'h10 || startGid[17] != 1) begin
      bad++; $display("FAIL maxpkt_resume: got %h id %0d want 10 id 1", startData[17], startGid[17]);
    end
    total++; if (startData[20] !== 8'h13) begin bad++; $display("FAIL maxpkt_tail: got %h want 13", startData[20]); end
    total++; if (grantCnt != 3 || grantLog[0] != 1 || grantLog[1] != 3 || grantLog[2] != 1) begin
      bad++; $display("FAIL maxpkt_grants: got cnt=%0d %0d,%0d,%0d want 3 grants 1,3,1", grantCnt, grantLog[0], grantLog[1], grantLog[2]);
    end
    total++; if (grant_valid !== 1'b1 || grant_id !== 3'd1) begin
      bad++; $display("FAIL maxpkt_held: got gv=%b id=%0d want gv=1 id=1", grant_valid, grant_id);
    end
    total++; if (readyCnt[1] != 20 || readyCnt[3] != 1) begin
      bad++; $display("FAIL maxpkt_ready: got r1=%0d r3=%0d want 20 1", readyCnt[1], readyCnt[3]);
    end
  endtask

  task automatic test_timeout();
    doReset();
    neverBusy = 1'b1;
    push(2, 8'h55, 1'b0);
    push(2, 8'h56, 1'b1);
    for (int k = 0; k < 20 && !tx_start; k++) @(negedge clk);
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL timeout_no_start: got %b want 1", tx_start); end
    repeat (7) @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
    for (int k = 0; k < 100 && grant_valid; k++) @(negedge clk);
    total++; if (grant_valid !== 1'b0 || startCnt != 2) begin
      bad++; $display("FAIL timeout_recover: got gv=%b starts=%0d want gv=0 starts=2", grant_valid, startCnt);
    end
    total++; if (startData[1] !== 8'h56) begin bad++; $display("FAIL timeout_second_byte: got %h want 56", startData[1]); end
    repeat (10) @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    doReset();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_cleared: got %b want 0", timeout_err); end
  endtask

  task automatic test_busy_held();
    doReset();
    forceBusy = 1'b1;
    repeat (2) @(negedge clk);
    push(1, 8'h9A, 1'b1);
    repeat (12) @(negedge clk);
    total++; if (startCnt != 0) begin bad++; $display("FAIL held_withheld: got %0d starts want 0", startCnt); end
    total++; if (tx_data !== 8'h9A || grant_valid !== 1'b1 || grant_id !== 3'd1) begin
      bad++; $display("FAIL held_state: got data=%h gv=%b id=%0d want 9a 1 1", tx_data, grant_valid, grant_id);
    end
    forceBusy = 1'b0;
    for (int k = 0; k < 20 && startCnt < 1; k++) @(negedge clk);
    total++; if (startCnt != 1 || startData[0] !== 8'h9A) begin
      bad++; $display("FAIL held_release_start: got %0d starts data %h want 1 9a", startCnt, startData[0]);
    end
    for (int k = 0; k < 50 && grant_valid; k++) @(negedge clk);
    total++; if (startCnt != 1 || tx_data !== 8'h9A || grant_valid !== 1'b0) begin
      bad++; $display("FAIL held_single_pulse: got starts=%0d data=%h gv=%b want 1 9a 0", startCnt, tx_data, grant_valid);
    end
    total++; if (violations != 0) begin bad++; $display("FAIL held_protocol: got %0d violations want 0", violations); end
  endtask

  task automatic test_reset_mid();
    doReset();
    busyLen = 6;
    push(2, 8'h21, 1'b1);
    for (int k = 0; k < 100 && (startCnt < 1 || grant_valid); k++) @(negedge clk);
    busyLen = 50;
    clearLogs();
    push(3, 8'h31, 1'b0);
    push(3, 8'h32, 1'b0);
    push(3, 8'h33, 1'b1);
    for (int k = 0; k < 100 && !(grant_valid && tx_busy && startCnt >= 1); k++) @(negedge clk);
    @(negedge clk);
    total++; if (tx_busy !== 1'b1 || grant_valid !== 1'b1) begin
      bad++; $display("FAIL midrst_setup: got busy=%b gv=%b want 1 1", tx_busy, grant_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (grant_valid !== 1'b0 || req_ready !== 4'b0 || tx_start !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl: got gv=%b rdy=%b start=%b want 0 0000 0", grant_valid, req_ready, tx_start);
    end
    total++; if (tx_data !== 8'h00 || grant_id !== 3'd0 || timeout_err !== 1'b0) begin
      bad++; $display("FAIL midrst_data: got data=%h id=%0d terr=%b want 00 0 0", tx_data, grant_id, timeout_err);
    end
    clearLogs();
    push(0, 8'h30, 1'b1);
    for (int k = 0; k < 200 && grantCnt < 1; k++) @(negedge clk);
    total++; if (grantCnt < 1 || grantLog[0] != 0) begin
      bad++; $display("FAIL midrst_pointer: got cnt=%0d first=%0d want first grant 0", grantCnt, grantLog[0]);
    end
    for (int k = 0; k < 200 && startCnt < 1; k++) @(negedge clk);
    total++; if (startCnt < 1 || startData[0] !== 8'h30) begin
      bad++; $display("FAIL midrst_new_byte: got cnt=%0d data=%h want 30", startCnt, startData[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_maxpkt();
    test_timeout();
    test_busy_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
